w_stage_grf: RTL and testbench
==============================

Name: w_stage_grf

Overview:
- Writeback stage of the P7 pipeline, directly downstream of the W pipeline register.
- Extends load data, selects the writeback source, and owns the 32x32 general register file.
- Provides two combinational read ports to the D stage, with internal write-to-read bypass.
- Exports the final writeback value (WD_W) to the forwarding network.

Parameters:
- DATA_W, 32, register and datapath width
- REG_N, 32, number of architectural registers (address width fixed at 5)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- A_DR_W  input  2  byte offset of load address, from W pipeline register
- A3_W  input  5  destination register; 0 = no write
- ALU_O_W  input  32  ALU result
- DR_W  input  32  raw word read from data memory
- PC8_W  input  32  PC+8, link value
- CP0_RD_W  input  32  CP0 read data, for mfc0
- WBSel_W  input  2  writeback source: 0 ALU, 1 load, 2 PC8, 3 CP0
- LdType_W  input  3  0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh; 5-7 behave as lw
- A1_D  input  5  read address, port 1 (rs)
- A2_D  input  5  read address, port 2 (rt)
- RD1_D  output  32  read data, port 1
- RD2_D  output  32  read data, port 2
- WD_W  output  32  final writeback value, for forwarding
- WCNT  output  32  count of committed register writes

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. Sampled only on posedge clk.
- Reset:
  - All REG_N registers clear to 0.
  - WCNT clears to 0.
  - Reset wins over a simultaneous write: the register is not updated and WCNT is not incremented.
- Load extension (combinational), selected by A_DR_W:
  - Byte = DR_W[8*A_DR_W +: 8].
  - Half = DR_W[31:16] if A_DR_W[1] = 1, else DR_W[15:0]. A_DR_W[0] is ignored for halfwords; misalignment is trapped upstream.
  - lbu and lhu zero-extend; lb and lh sign-extend.
- WD_W (combinational):
  - Mux by WBSel_W: 0 ALU_O_W, 1 extended load value, 2 PC8_W, 3 CP0_RD_W.
  - WD_W is valid regardless of A3_W.
- Write:
  - On posedge clk, when reset = 0 and A3_W != 0: reg[A3_W] <= WD_W, and WCNT <= WCNT + 1.
  - WCNT wraps modulo 2^32.
  - A3_W = 0 performs no write and no count. reg[0] always reads 0.
- Read (combinational, zero latency):
  - RD1_D = 0 if A1_D = 0.
  - Else RD1_D = WD_W if A1_D == A3_W (bypass of the write landing this cycle).
  - Else RD1_D = reg[A1_D].
  - RD2_D follows the same rule with A2_D.
  - Both ports may hit the bypass at the same time.
  - The bypass path is ungated by reset; reads are combinational and reset only affects stored state.
- Flush: the W pipeline register zeroes A3_W on exception flush, so a flushed slot produces no write. This block has no flush input.
- No stall input: the W stage never stalls, and a write occurs every cycle A3_W != 0.

Optional Feature:
- Macro: GRF_TRACE_EN.
- Defined:
  - Add input PC_W [31:0].
  - On every committed write, simulation prints "@<PC_W hex>: $<A3_W dec> <= <WD_W hex>" using $display at posedge clk.
  - The print is synthesis-transparent.
- Undefined: the port and the print are absent. Datapath behaviour is identical.

Test Plan:
- Reset held 2 cycles, then A1_D = 5, A2_D = 31 → RD1_D = 0, RD2_D = 0, WCNT = 0.
- A3_W = 8, WBSel_W = 0, ALU_O_W = 0x12345678, A1_D = 8 in the same cycle → RD1_D = 0x12345678 via bypass. Next cycle with A3_W = 0 → RD1_D still 0x12345678. WCNT = 1.
- DR_W = 0x80FF7F01, WBSel_W = 1, A3_W = 9, sweeping loads:
  - lb at A_DR_W 0/1/2/3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - lbu at A_DR_W 3 → 0x00000080.
  - lh at A_DR_W 2 → 0xFFFF80FF.
  - lhu at A_DR_W 0 → 0x00007F01.
- A3_W = 0, WBSel_W = 2, PC8_W = 0x3008 → WD_W = 0x3008, no register changes, WCNT unchanged, RD of $0 = 0.
- Write to reg 31 with PC8_W = 0x3010 in the same cycle as reset = 1 → next cycle reg 31 = 0, WCNT = 0.
- Set WCNT to 0xFFFFFFFF (via 2^32-1 writes, or a forced value in the bench), then one write → WCNT = 0.

Source files
------------

// File: rtl/w_stage_grf.sv
// +--------------------------------------------------------------------------+
// | w_stage_grf : P7 writeback stage, load extension, WB mux, 32x32 GRF      |
// | Optional GRF_TRACE_EN adds PC_W and a commit trace.  Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module w_stage_grf #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
`ifdef GRF_TRACE_EN
  input  logic [31:0]       PC_W,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        A_DR_W,
  input  logic [4:0]        A3_W,
  input  logic [DATA_W-1:0] ALU_O_W,
  input  logic [DATA_W-1:0] DR_W,
  input  logic [DATA_W-1:0] PC8_W,
  input  logic [DATA_W-1:0] CP0_RD_W,
  input  logic [1:0]        WBSel_W,
  input  logic [2:0]        LdType_W,
  input  logic [4:0]        A1_D,
  input  logic [4:0]        A2_D,
  output logic [DATA_W-1:0] RD1_D,
  output logic [DATA_W-1:0] RD2_D,
  output logic [DATA_W-1:0] WD_W,
  output logic [31:0]       WCNT
);

  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [31:0]       wcnt_q;
  logic [31:0]       wcnt_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;
  logic              wr_en;

  always_comb begin
    ld_byte = DR_W[7:0];
    case (A_DR_W)
      2'd0: ld_byte = DR_W[7:0];
      2'd1: ld_byte = DR_W[15:8];
      2'd2: ld_byte = DR_W[23:16];
      2'd3: ld_byte = DR_W[31:24];
    endcase
    // Halfword alignment is guaranteed upstream, so only bit 1 matters.
    ld_half = A_DR_W[1] ? DR_W[31:16] : DR_W[15:0];
  end

  always_comb begin
    ld_ext = DR_W;
    case (LdType_W)
      LD_LBU:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      LD_LB:   ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LD_LHU:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
      LD_LH:   ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      default: ld_ext = DR_W;
    endcase
  end

  always_comb begin
    WD_W = ALU_O_W;
    case (WBSel_W)
      2'd0: WD_W = ALU_O_W;
      2'd1: WD_W = ld_ext;
      2'd2: WD_W = PC8_W;
      2'd3: WD_W = CP0_RD_W;
    endcase
  end

  assign wr_en = (A3_W != 5'd0);

  always_comb begin
    regs_d = regs_q;
    wcnt_d = wcnt_q;
    if (wr_en) begin
      regs_d[A3_W] = WD_W;
      wcnt_d       = wcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
      wcnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Same-cycle bypass: a reader sees the value being committed this cycle.
  always_comb begin
    RD1_D = regs_q[A1_D];
    if (A1_D == 5'd0) begin
      RD1_D = '0;
    end else if (A1_D == A3_W) begin
      RD1_D = WD_W;
    end
    RD2_D = regs_q[A2_D];
    if (A2_D == 5'd0) begin
      RD2_D = '0;
    end else if (A2_D == A3_W) begin
      RD2_D = WD_W;
    end
  end

  assign WCNT = wcnt_q;

`ifdef GRF_TRACE_EN
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      $display("@%h: $%0d <= %h", PC_W, A3_W, WD_W);
    end
  end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_w_stage_grf.sv
// Directed, table-driven bench for w_stage_grf.
`default_nettype none

module tb_w_stage_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  A_DR_W;
  logic [4:0]  A3_W;
  logic [31:0] ALU_O_W, DR_W, PC8_W, CP0_RD_W;
  logic [1:0]  WBSel_W;
  logic [2:0]  LdType_W;
  logic [4:0]  A1_D, A2_D;
  logic [31:0] RD1_D, RD2_D, WD_W, WCNT;
`ifdef GRF_TRACE_EN
  logic [31:0] PC_W = 32'h0000_3000;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_wcnt;

  always #5 clk = ~clk;

  w_stage_grf dut (
`ifdef GRF_TRACE_EN
    .PC_W     (PC_W),
`endif
    .clk      (clk),
    .reset    (reset),
    .A_DR_W   (A_DR_W),
    .A3_W     (A3_W),
    .ALU_O_W  (ALU_O_W),
    .DR_W     (DR_W),
    .PC8_W    (PC8_W),
    .CP0_RD_W (CP0_RD_W),
    .WBSel_W  (WBSel_W),
    .LdType_W (LdType_W),
    .A1_D     (A1_D),
    .A2_D     (A2_D),
    .RD1_D    (RD1_D),
    .RD2_D    (RD2_D),
    .WD_W     (WD_W),
    .WCNT     (WCNT)
  );

  typedef struct {
    logic [1:0]  a_dr;
    logic [4:0]  a3;
    logic [31:0] alu;
    logic [31:0] dr;
    logic [31:0] pc8;
    logic [31:0] cp0;
    logic [1:0]  wbsel;
    logic [2:0]  ld;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e_wd;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    string       name;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    A_DR_W = 2'd0; A3_W = 5'd0; ALU_O_W = '0; DR_W = '0; PC8_W = '0;
    CP0_RD_W = '0; WBSel_W = 2'd0; LdType_W = 3'd0; A1_D = 5'd0; A2_D = 5'd0;
  endtask

  localparam logic [31:0] D = 32'h80FF_7F01;

  initial begin
    vecs[0]  = '{2'd0, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd2, 5'd9, 5'd8, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678, "lb0"};
    vecs[1]  = '{2'd1, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd2, 5'd9, 5'd8, 32'h0000_007F, 32'h0000_007F, 32'h1234_5678, "lb1"};
    vecs[2]  = '{2'd2, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd2, 5'd9, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, "lb2"};
    vecs[3]  = '{2'd3, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd2, 5'd9, 5'd8, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'h1234_5678, "lb3"};
    vecs[4]  = '{2'd3, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd1, 5'd9, 5'd8, 32'h0000_0080, 32'h0000_0080, 32'h1234_5678, "lbu3"};
    vecs[5]  = '{2'd2, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd4, 5'd9, 5'd8, 32'hFFFF_80FF, 32'hFFFF_80FF, 32'h1234_5678, "lh2"};
    vecs[6]  = '{2'd0, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd3, 5'd9, 5'd8, 32'h0000_7F01, 32'h0000_7F01, 32'h1234_5678, "lhu0"};
    vecs[7]  = '{2'd0, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd0, 5'd9, 5'd8, D,             D,             32'h1234_5678, "lw0"};
    vecs[8]  = '{2'd1, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd6, 5'd9, 5'd8, D,             D,             32'h1234_5678, "ld6_as_lw"};
    vecs[9]  = '{2'd3, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd3, 5'd9, 5'd8, 32'h0000_80FF, 32'h0000_80FF, 32'h1234_5678, "lhu3"};
    vecs[10] = '{2'd1, 5'd9,  32'h0, D, 32'h0, 32'h0, 2'd1, 3'd4, 5'd9, 5'd8, 32'h0000_7F01, 32'h0000_7F01, 32'h1234_5678, "lh1"};
    vecs[11] = '{2'd0, 5'd0,  32'h0, D, 32'h0000_3008, 32'h0, 2'd2, 3'd0, 5'd0, 5'd9, 32'h0000_3008, 32'h0, 32'h0000_7F01, "pc8_nowrite"};
    vecs[12] = '{2'd0, 5'd31, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 2'd3, 3'd0, 5'd31, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "cp0_dual_bypass"};
    vecs[13] = '{2'd0, 5'd5,  32'hCAFE_0000, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 5'd31, 5'd5, 32'hCAFE_0000, 32'hDEAD_BEEF, 32'hCAFE_0000, "alu_mixed"};

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    A1_D = 5'd5; A2_D = 5'd31;
    #1;
    chk("rst_rd1", RD1_D, 32'h0);
    chk("rst_rd2", RD2_D, 32'h0);
    chk("rst_wcnt", WCNT, 32'h0);

    // Bypass, then read back from storage.
    @(negedge clk);
    A3_W = 5'd8; WBSel_W = 2'd0; ALU_O_W = 32'h1234_5678; A1_D = 5'd8;
    #1;
    chk("byp_rd1", RD1_D, 32'h1234_5678);
    @(negedge clk);
    A3_W = 5'd0;
    #1;
    chk("stored_rd1", RD1_D, 32'h1234_5678);
    chk("wcnt_one", WCNT, 32'd1);
    exp_wcnt = 32'd1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      A_DR_W = vecs[i].a_dr; A3_W = vecs[i].a3; ALU_O_W = vecs[i].alu;
      DR_W = vecs[i].dr; PC8_W = vecs[i].pc8; CP0_RD_W = vecs[i].cp0;
      WBSel_W = vecs[i].wbsel; LdType_W = vecs[i].ld;
      A1_D = vecs[i].a1; A2_D = vecs[i].a2;
      #1;
      chk({vecs[i].name, "_wd"},   WD_W,  vecs[i].e_wd);
      chk({vecs[i].name, "_rd1"},  RD1_D, vecs[i].e_rd1);
      chk({vecs[i].name, "_rd2"},  RD2_D, vecs[i].e_rd2);
      chk({vecs[i].name, "_wcnt"}, WCNT,  exp_wcnt);
      if (vecs[i].a3 != 5'd0) exp_wcnt = exp_wcnt + 32'd1;
    end
    @(negedge clk);
    idle();
    A1_D = 5'd5;
    #1;
    chk("after_tbl_wcnt", WCNT, exp_wcnt);
    chk("after_tbl_reg5", RD1_D, 32'hCAFE_0000);

    // Reset beats a simultaneous write.
    reset = 1'b1;
    A3_W = 5'd31; WBSel_W = 2'd2; PC8_W = 32'h0000_3010;
    @(negedge clk);
    reset = 1'b0;
    idle();
    A1_D = 5'd31; A2_D = 5'd8;
    #1;
    chk("rstwin_r31", RD1_D, 32'h0);
    chk("rstwin_r8", RD2_D, 32'h0);
    chk("rstwin_wcnt", WCNT, 32'h0);

    // Counter wrap from a forced all-ones value.
    force dut.wcnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wcnt_q;
    #1;
    chk("wcnt_preset", WCNT, 32'hFFFF_FFFF);
    @(negedge clk);
    A3_W = 5'd3; WBSel_W = 2'd0; ALU_O_W = 32'h0000_0001;
    @(negedge clk);
    idle();
    A1_D = 5'd3;
    #1;
    chk("wcnt_wrap", WCNT, 32'h0);
    chk("wrap_reg3", RD1_D, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
